// File: rtl/calc_op_issuer.sv
// ---------------------------------------------------------------------------
// calc_op_issuer
//
// Program-sequencing front end for the calculator datapath. A start pulse
// walks the instruction memory from address 0, one 32-bit word at a time,
// through a synchronous read port. Each word is split into an opcode and two
// 14-bit operands. Operations are then handed to the calculator over a
// valid/ready handshake.
//
// Word format: [31:28] opcode, [27:14] operand A, [13:0] operand B.
//   opcode 0x0 : NOP. The word is consumed and never issued.
//   opcode 0xF : HALT. The run ends and the word is not issued.
//   other      : issued unmodified to the calculator.
//
// Ports
//   clk          : single clock; all state changes on its rising edge
//   reset        : synchronous, active-high
//   start        : one-cycle run request; honoured only while idle
//   mem_rd       : instruction memory read strobe (asserted in FETCH)
//   mem_addr     : instruction memory address (the registered pc)
//   mem_rdata    : read data, valid one cycle after the mem_rd cycle
//   op_valid     : operation presented to the calculator
//   op_ready     : calculator accepts the operation this cycle
//   op_code      : operation code
//   op_a, op_b   : operands
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse when a run ends
//   issued_count : operations accepted in the current or most recent run
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module calc_op_issuer #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [3:0]    op_code,
    output logic [13:0]   op_a,
    output logic [13:0]   op_b,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   issued_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0]    OPC_NOP  = 4'h0;
    localparam logic [3:0]    OPC_HALT = 4'hF;
    // Last program address. Finishing this address ends the run.
    // The pc never wraps back to 0.
    localparam logic [AW-1:0] PC_LAST  = '1;

    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   pc_reg;
    logic [AW-1:0]   pc_next;
    logic [AW:0]     count_reg;
    logic [AW:0]     count_next;
    logic            op_valid_reg;
    logic            done_reg;
    logic [3:0]      op_code_reg;
    logic [13:0]     op_a_reg;
    logic [13:0]     op_b_reg;
    logic            load_op;

    logic [3:0]      rd_opcode;
    logic            pc_at_last;

    assign rd_opcode  = mem_rdata[31:28];
    assign pc_at_last = (pc_reg == PC_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        load_op    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = '0;
                    count_next = '0;
                end
            end

            S_FETCH: begin
                state_next = S_DECODE;
            end

            S_DECODE: begin
                if (rd_opcode == OPC_HALT) begin
                    state_next = S_DONE;
                end else if (rd_opcode == OPC_NOP) begin
                    if (pc_at_last) begin
                        state_next = S_DONE;
                    end else begin
                        pc_next    = pc_reg + AW'(1);
                        state_next = S_FETCH;
                    end
                end else begin
                    load_op    = 1'b1;
                    state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // op_valid is high for the whole of ISSUE, so op_ready
                // alone marks the completed handshake here.
                if (op_ready) begin
                    count_next = count_reg + (AW+1)'(1);
                    if (pc_at_last) begin
                        state_next = S_DONE;
                    end else begin
                        pc_next    = pc_reg + AW'(1);
                        state_next = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            pc_reg       <= '0;
            count_reg    <= '0;
            op_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            op_code_reg  <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            count_reg    <= count_next;
            // These flags are registered copies of "next state is X".
            // They therefore line up exactly with the state register.
            op_valid_reg <= (state_next == S_ISSUE);
            done_reg     <= (state_next == S_DONE);
            // Operation fields are captured only on entry to ISSUE.
            // They stay stable while the calculator stalls.
            if (load_op) begin
                op_code_reg <= mem_rdata[31:28];
                op_a_reg    <= mem_rdata[27:14];
                op_b_reg    <= mem_rdata[13:0];
            end
        end
    end

    assign mem_rd       = (state_reg == S_FETCH);
    assign busy         = (state_reg != S_IDLE);
    assign mem_addr     = pc_reg;
    assign op_valid     = op_valid_reg;
    assign op_code      = op_code_reg;
    assign op_a         = op_a_reg;
    assign op_b         = op_b_reg;
    assign done         = done_reg;
    assign issued_count = count_reg;

endmodule

// File: tb/tb_calc_op_issuer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for calc_op_issuer (AW = 8).
// A behavioural model walks the program array to predict the issued
// operations, the fetch sequence and the run length. A negedge monitor
// records what the DUT actually did.
// ---------------------------------------------------------------------------
module tb_calc_op_issuer;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [3:0]    c;
        logic [13:0]   a;
        logic [13:0]   b;
        logic [AW-1:0] addr;
    } op_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic          op_valid;
    logic          op_ready = 1'b0;
    logic [3:0]    op_code;
    logic [13:0]   op_a;
    logic [13:0]   op_b;
    logic          busy;
    logic          done;
    logic [AW:0]   issued_count;

    logic [31:0]   mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

    calc_op_issuer #(.AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .done         (done),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       op_ready = 1'b1;
            1:       op_ready = ($urandom_range(0, 2) != 0);
            default: op_ready = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          start_cyc, done_cyc, first_valid_cyc, done_cnt, proto_err;
    op_t         got_q[$];
    logic [AW-1:0] fetch_q[$];
    logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
    logic [3:0]  pcode;
    logic [13:0] pa, pb;

    always @(negedge clk) begin
        op_t g;
        cyc++;
        if (start && !busy && !reset) start_cyc = cyc;
        if (mem_rd) fetch_q.push_back(mem_addr);
        if (op_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; end
        // stalled operation must hold steady
        if (pv && !pr && !prst &&
            (op_valid !== 1'b1 || op_code !== pcode || op_a !== pa || op_b !== pb))
            proto_err++;
        // valid must drop in the cycle after acceptance
        if (pv && pr && !prst && op_valid === 1'b1) proto_err++;
        if (op_valid === 1'b1 && op_ready && !reset) begin
            g.c = op_code; g.a = op_a; g.b = op_b; g.addr = mem_addr;
            got_q.push_back(g);
            $display("op  cyc=%0d addr=%0d code=%h a=%0d b=%0d", cyc, mem_addr, op_code, op_a, op_b);
        end
        pv = (op_valid === 1'b1); pr = op_ready; prst = reset;
        pcode = op_code; pa = op_a; pb = op_b;
    end

    // ---------------- model / helpers ----------------
    op_t exp_q[$];
    int  exp_fetch_n;
    int  exp_first_idx;

    function automatic logic [31:0] mk(input logic [3:0] c, input int a, input int b);
        return {c, a[13:0], b[13:0]};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    endtask

    // Walk the program as the specification describes it.
    task automatic build_model();
        op_t e;
        logic [31:0] w;
        exp_q.delete();
        exp_fetch_n   = 0;
        exp_first_idx = -1;
        for (int a = 0; a < DEPTH; a++) begin
            w = mem[a];
            exp_fetch_n++;
            if (w[31:28] == 4'hF) break;
            if (w[31:28] != 4'h0) begin
                e.c = w[31:28]; e.a = w[27:14]; e.b = w[13:0]; e.addr = a[AW-1:0];
                if (exp_first_idx < 0) exp_first_idx = a;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_run();
        build_model();
        got_q.delete(); fetch_q.delete();
        done_cnt = 0; proto_err = 0;
        start_cyc = -1; done_cyc = -1; first_valid_cyc = -1;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic finish_run(input string name, input bit timed);
        int  i;
        bit  ok;
        for (i = 0; i < 5000 && done_cnt == 0; i++) tick();
        if (done_cnt == 0) begin
            $display("FAIL %s timeout: done never seen, required within 5000 cycles", name);
            n_checks++;
        end
        repeat (3) tick();

        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL %s handshake count got %0d want %0d", name, got_q.size(), exp_q.size());
        else n_pass++;

        ok = 1'b1;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            if (got_q[k] !== exp_q[k]) begin
                if (ok) $display("FAIL %s op[%0d] got %h want %h", name, k, got_q[k], exp_q[k]);
                ok = 1'b0;
            end
        n_checks++;
        if (ok) n_pass++;

        ok = (fetch_q.size() == exp_fetch_n);
        for (int k = 0; k < fetch_q.size(); k++) if (fetch_q[k] !== k[AW-1:0]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL %s fetch sequence got %0d fetches want 0..%0d", name, fetch_q.size(), exp_fetch_n - 1);
        else n_pass++;

        n_checks++;
        if (done_cnt !== 1) $display("FAIL %s done pulses got %0d want 1", name, done_cnt);
        else n_pass++;

        n_checks++;
        if (issued_count !== (AW+1)'(exp_q.size()))
            $display("FAIL %s issued_count got %0d want %0d", name, issued_count, exp_q.size());
        else n_pass++;

        n_checks++;
        if (busy !== 1'b0 || mem_rd !== 1'b0 || op_valid !== 1'b0 || proto_err !== 0)
            $display("FAIL %s end state busy=%b mem_rd=%b op_valid=%b proto_err=%0d want 0/0/0/0",
                     name, busy, mem_rd, op_valid, proto_err);
        else n_pass++;

        if (timed) begin
            n_checks++;
            if (done_cyc !== start_cyc + 1 + 2 * exp_fetch_n + exp_q.size())
                $display("FAIL %s done latency got %0d want %0d", name, done_cyc - start_cyc,
                         1 + 2 * exp_fetch_n + exp_q.size());
            else n_pass++;
            if (exp_first_idx >= 0) begin
                n_checks++;
                if (first_valid_cyc !== start_cyc + 3 + 2 * exp_first_idx)
                    $display("FAIL %s first op_valid offset got %0d want %0d", name,
                             first_valid_cyc - start_cyc, 3 + 2 * exp_first_idx);
                else n_pass++;
            end
        end
        $display("run %s: %0d ops issued", name, got_q.size());
    endtask

    task automatic load_basic();
        fill_random();
        mem[0] = mk(4'h1, 5, 3);
        mem[1] = mk(4'h2, 10, 4);
        mem[2] = mk(4'hF, 0, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ready_mode = 0;
        repeat (3) tick();
        n_checks++;
        if ({mem_rd, mem_addr, op_valid, op_code, op_a, op_b, busy, done, issued_count} !== '0)
            $display("FAIL reset outputs got rd=%b addr=%h v=%b c=%h a=%h b=%h busy=%b done=%b cnt=%h want all 0",
                     mem_rd, mem_addr, op_valid, op_code, op_a, op_b, busy, done, issued_count);
        else n_pass++;
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        load_basic();
        ready_mode = 0;
        start_run();
        finish_run("basic", 1'b1);
    endtask

    task automatic test_backpressure();
        logic [3:0]  c0;
        logic [13:0] a0, b0;
        int i;
        load_basic();
        ready_mode = 2;
        start_run();
        for (i = 0; i < 50 && op_valid !== 1'b1; i++) tick();
        c0 = op_code; a0 = op_a; b0 = op_b;
        n_checks++;
        if (op_valid !== 1'b1) $display("FAIL stall op_valid got %b want 1", op_valid);
        else n_pass++;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_checks++;
            if (op_valid !== 1'b1 || op_code !== c0 || op_a !== a0 || op_b !== b0)
                $display("FAIL stall cycle %0d got v=%b %h/%0d/%0d want 1 %h/%0d/%0d",
                         k, op_valid, op_code, op_a, op_b, c0, a0, b0);
            else n_pass++;
        end
        ready_mode = 0;
        finish_run("backpressure", 1'b0);
    endtask

    task automatic test_nop();
        fill_random();
        mem[0] = mk(4'h0, 1, 1);
        mem[1] = mk(4'h0, 2, 2);
        mem[2] = mk(4'h3, 7, 6);
        mem[3] = mk(4'hF, 0, 0);
        ready_mode = 0;
        start_run();
        finish_run("nop", 1'b1);
    endtask

    task automatic test_full_program();
        for (int i = 0; i < DEPTH; i++)
            mem[i] = mk(4'($urandom_range(1, 14)), $urandom, $urandom);
        ready_mode = 0;
        start_run();
        finish_run("full", 1'b1);
        n_checks++;
        if (mem_addr !== AW'(DEPTH - 1) || issued_count !== (AW+1)'(DEPTH))
            $display("FAIL full end addr=%0d cnt=%0d want %0d/%0d", mem_addr, issued_count, DEPTH - 1, DEPTH);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(0, 199);
                if (r < 2)       mem[i] = mk(4'hF, $urandom, $urandom);
                else if (r < 40) mem[i] = mk(4'h0, $urandom, $urandom);
                else             mem[i] = mk(4'($urandom_range(1, 14)), $urandom, $urandom);
            end
            ready_mode = 1;
            start_run();
            finish_run("random", 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        int i;
        fill_random();
        for (int k = 0; k < 6; k++) mem[k] = mk(4'h5, k + 1, k + 2);
        mem[6] = mk(4'hF, 0, 0);
        ready_mode = 0;
        start_run();
        for (i = 0; i < 50 && issued_count < 2; i++) tick();
        ready_mode = 2;
        for (i = 0; i < 50 && !(op_valid === 1'b1 && op_ready === 1'b0); i++) tick();
        n_checks++;
        if (issued_count !== 2 || op_valid !== 1'b1)
            $display("FAIL midrun pre-reset cnt=%0d v=%b want 2/1", issued_count, op_valid);
        else n_pass++;
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0 || issued_count !== '0 || op_code !== '0 || mem_addr !== '0 || done !== 1'b0)
            $display("FAIL midrun reset got v=%b busy=%b cnt=%0d code=%h addr=%0d done=%b want all 0",
                     op_valid, busy, issued_count, op_code, mem_addr, done);
        else n_pass++;
        ready_mode = 0;
        tick();
        start_run();
        finish_run("rerun", 1'b1);
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 40; i++) mem[i] = mk(4'($urandom_range(0, 14)), $urandom, $urandom);
        mem[40] = mk(4'hF, 0, 0);
        ready_mode = 1;
        start_run();
        for (int k = 0; k < 8; k++) begin
            repeat (7) tick();
            start = 1'b1; tick(); start = 1'b0;
        end
        finish_run("start_ignored", 1'b0);

        ready_mode = 0;
        reset = 1'b1; start = 1'b1; tick();
        reset = 1'b0; start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || mem_rd !== 1'b0)
            $display("FAIL start_with_reset busy=%b mem_rd=%b want 0/0", busy, mem_rd);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_nop();
        test_full_program();
        test_random();
        test_reset_mid_run();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
